// File: rtl/riscv_defines.sv
// Shared definitions for the fetch front end: FSM states, boot PC and the
// layout of the F->D pipeline register.
package riscv_defines;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_RUN,
    FS_HALT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        valid;
    logic        instmisalign;
  } fd_reg_t;

endpackage

// File: rtl/next_pc_sel.sv
// Priority mux choosing the next fetch PC from trap, redirect, stall and
// sequential sources, gated by the fetch FSM state.
module next_pc_sel
  import riscv_defines::*;
#(
  parameter int XLEN = 32
) (
  input  fetch_state_t    state_i,
  input  logic            trap_en_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            redirect_en_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_f_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] next_pc_o
);

  // Wraps modulo 2^XLEN; targets are never realigned.
  assign pc_plus4_o = pc_i + XLEN'(4);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    next_pc_o = pc_i;
    case (state_i)
      FS_RUN: begin
        if (trap_en_i)          next_pc_o = trap_pc_i;
        else if (redirect_en_i) next_pc_o = redirect_pc_i;
        else if (stall_f_i)     next_pc_o = pc_i;
        else                    next_pc_o = pc_plus4_o;
      end
      FS_HALT: begin
        if (trap_en_i) next_pc_o = trap_pc_i;
      end
      default: next_pc_o = pc_i;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// PC-generation stage: fetch FSM, architectural PC and the F->D metadata
// register that lines up with instruction memory's synchronous read.
module fetch_stage
  import riscv_defines::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            start,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic            instmisalign,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic            valid_d,
  output logic            instmisalign_d,
  output logic            halted
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, next_pc, pc_plus4;
  fd_reg_t         fd_q, fd_d;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .state_i       (state_q),
    .trap_en_i     (trap_en),
    .trap_pc_i     (trap_pc),
    .redirect_en_i (redirect_en),
    .redirect_pc_i (redirect_pc),
    .stall_f_i     (stall_f),
    .pc_i          (pc_q),
    .pc_plus4_o    (pc_plus4),
    .next_pc_o     (next_pc)
  );

  assign instmisalign = |pc_q[1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_BOOT: state_d = FS_RUN;
      FS_RUN:  if (halt_req && !trap_en) state_d = FS_HALT;
      FS_HALT: if (resume || trap_en) state_d = FS_RUN;
      default: state_d = FS_BOOT;
    endcase
  end

  // A misaligned or non-RUN fetch still records its PC for mepc/mtval.
  always_comb begin
    fd_d = fd_q;
    if (flush_d || instmisalign || (state_q != FS_RUN)) begin
      fd_d = '{pc: pc_q, pcplus4: pc_plus4, valid: 1'b0, instmisalign: instmisalign};
    end else if (!stall_d) begin
      fd_d = '{pc: pc_q, pcplus4: pc_plus4, valid: 1'b1, instmisalign: 1'b0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q <= FS_BOOT;
      pc_q    <= RESET_PC;
      fd_q    <= '{pc: 32'h0, pcplus4: 32'h4, valid: 1'b0, instmisalign: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= next_pc;
      fd_q    <= fd_d;
    end
  end

  assign pc             = pc_q;
  assign pc_d           = fd_q.pc;
  assign pcplus4_d      = fd_q.pcplus4;
  assign valid_d        = fd_q.valid;
  assign instmisalign_d = fd_q.instmisalign;
  assign halted         = (state_q == FS_HALT);

endmodule
